// File: rtl/softmax_pkg.sv
// Shared constants, serializer state encoding and index-width helper for the softmax stages.
package softmax_pkg;

  localparam int W      = 16;
  localparam int Q_FRAC = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  // Never returns zero so a one-bit index is still legal for tiny vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_argmax_tracker.sv
// Running argmax over the handshaked elements of one streamed vector.
// Only compiled when SOFTMAX_ARGMAX_EN is defined.
`ifdef SOFTMAX_ARGMAX_EN
module softmax_argmax_tracker #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         elem_i,
  input  logic [$clog2(N)-1:0] idx_i,
  input  logic                 hs_i,
  input  logic                 start_i,
  input  logic                 last_i,
  output logic                 argmax_valid,
  output logic [$clog2(N)-1:0] argmax_idx,
  output logic [W-1:0]         argmax_val
);
  import softmax_pkg::*;

  localparam int IW = idx_width(N);

  logic [W-1:0]  run_val_q, run_val_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic          am_valid_q, am_valid_d;
  logic [IW-1:0] am_idx_q, am_idx_d;
  logic [W-1:0]  am_val_q, am_val_d;
  logic          better;
  logic [W-1:0]  cand_val;
  logic [IW-1:0] cand_idx;

  // Strict greater-than keeps the earliest index on ties; a zero seed still lets index 0 win.
  always_comb begin
    better     = elem_i > run_val_q;
    cand_val   = better ? elem_i : run_val_q;
    cand_idx   = better ? idx_i  : run_idx_q;
    run_val_d  = run_val_q;
    run_idx_d  = run_idx_q;
    am_valid_d = hs_i && last_i;
    am_idx_d   = am_idx_q;
    am_val_d   = am_val_q;
    if (hs_i && last_i) begin
      am_idx_d = cand_idx;
      am_val_d = cand_val;
    end
    if (start_i) begin
      run_val_d = '0;
      run_idx_d = '0;
    end else if (hs_i) begin
      run_val_d = cand_val;
      run_idx_d = cand_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_val_q  <= '0;
      run_idx_q  <= '0;
      am_valid_q <= 1'b0;
      am_idx_q   <= '0;
      am_val_q   <= '0;
    end else begin
      run_val_q  <= run_val_d;
      run_idx_q  <= run_idx_d;
      am_valid_q <= am_valid_d;
      am_idx_q   <= am_idx_d;
      am_val_q   <= am_val_d;
    end
  end

  assign argmax_valid = am_valid_q;
  assign argmax_idx   = am_idx_q;
  assign argmax_val   = am_val_q;

endmodule
`endif

// File: rtl/softmax_prob_serializer.sv
// Captures a softmax probability vector and streams it out one element per valid/ready handshake.
// Optional running argmax over each streamed vector is enabled by defining SOFTMAX_ARGMAX_EN.
module softmax_prob_serializer #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [N*W-1:0]       prob_flat,
  output logic                 ready_in,
  output logic                 overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic                 argmax_valid,
  output logic [$clog2(N)-1:0] argmax_idx,
  output logic [W-1:0]         argmax_val
`endif
);
  import softmax_pkg::*;

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  ser_state_e    state_q, state_d;
  logic [N*W-1:0] buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic          handshake, final_hs, capture, drop;

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_idx   = idx_q;
  assign out_data  = buf_q[idx_q*W +: W];
  assign overflow  = overflow_q;

  // A capture on the final handshake reloads the buffer so the next vector follows without a bubble.
  always_comb begin
    handshake  = out_valid && out_ready;
    final_hs   = handshake && (idx_q == LAST_IDX);
    ready_in   = (state_q == IDLE) || final_hs;
    capture    = valid_in && ready_in;
    drop       = valid_in && !ready_in;
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    overflow_d = overflow_q || drop;
    if (capture) begin
      buf_d   = prob_flat;
      idx_d   = '0;
      state_d = STREAM;
    end else if (final_hs) begin
      idx_d   = '0;
      state_d = IDLE;
    end else if (handshake) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SOFTMAX_ARGMAX_EN
  softmax_argmax_tracker #(
    .N (N),
    .W (W)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .elem_i       (out_data),
    .idx_i        (idx_q),
    .hs_i         (handshake),
    .start_i      (capture),
    .last_i       (out_last),
    .argmax_valid (argmax_valid),
    .argmax_idx   (argmax_idx),
    .argmax_val   (argmax_val)
  );
`endif

endmodule

// File: tb/tb_softmax_prob_serializer.sv
// Randomised and directed bench for softmax_prob_serializer against a vector-level reference model.
// Argmax checks are active only when SOFTMAX_ARGMAX_EN is defined.
module tb_softmax_prob_serializer;

  localparam int N = 64;
  localparam int W = 16;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid_in = 1'b0;
  logic [N*W-1:0] prob_flat = '0;
  logic           ready_in;
  logic           overflow;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
`ifdef SOFTMAX_ARGMAX_EN
  logic           argmax_valid;
  logic [IW-1:0]  argmax_idx;
  logic [W-1:0]   argmax_val;
`endif

  int errors = 0;
  int checks = 0;

  softmax_prob_serializer #(
    .N (N),
    .W (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .prob_flat    (prob_flat),
    .ready_in     (ready_in),
    .overflow     (overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last)
`ifdef SOFTMAX_ARGMAX_EN
    ,
    .argmax_valid (argmax_valid),
    .argmax_idx   (argmax_idx),
    .argmax_val   (argmax_val)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [N*W-1:0] p, input logic r);
    valid_in  = v;
    prob_flat = p;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the vector currently on offer, the position within it, and the
  // argmax of the whole vector worked out once at capture time.
  logic [W-1:0] mVec [N];
  int           mIdx = 0;
  bit           mActive = 1'b0;
  bit           mOverflow = 1'b0;
  bit           expAmValid = 1'b0;
  int           expAmIdx = 0;
  logic [W-1:0] expAmVal = '0;
  int           pendIdx = 0;
  logic [W-1:0] pendVal = '0;

  always @(negedge clk) begin
    bit hs;
    bit fin;
    bit rdy;
    if (!rst) begin
      mActive    = 1'b0;
      mIdx       = 0;
      mOverflow  = 1'b0;
      expAmValid = 1'b0;
      expAmIdx   = 0;
      expAmVal   = '0;
      for (int i = 0; i < N; i++) mVec[i] = '0;
    end
    hs  = mActive && out_ready;
    fin = hs && (mIdx == N - 1);
    rdy = !mActive || fin;
    checkOutput("out_valid", out_valid, mActive);
    checkOutput("ready_in", ready_in, rdy);
    checkOutput("overflow", overflow, mOverflow);
    if (mActive) begin
      checkOutput("out_idx", out_idx, mIdx);
      checkOutput("out_data", out_data, mVec[mIdx]);
      checkOutput("out_last", out_last, mIdx == N - 1);
    end else begin
      checkOutput("out_last_idle", out_last, 1'b0);
    end
`ifdef SOFTMAX_ARGMAX_EN
    checkOutput("argmax_valid", argmax_valid, expAmValid);
    checkOutput("argmax_idx", argmax_idx, expAmIdx);
    checkOutput("argmax_val", argmax_val, expAmVal);
`endif
    if (rst) begin
      expAmValid = 1'b0;
      if (fin) begin
        expAmValid = 1'b1;
        expAmIdx   = pendIdx;
        expAmVal   = pendVal;
      end
      if (valid_in && rdy) begin
        for (int i = 0; i < N; i++) mVec[i] = prob_flat[i*W +: W];
        pendIdx = 0;
        pendVal = mVec[0];
        for (int i = 1; i < N; i++) begin
          if (mVec[i] > pendVal) begin
            pendVal = mVec[i];
            pendIdx = i;
          end
        end
        mIdx    = 0;
        mActive = 1'b1;
      end else if (fin) begin
        mActive = 1'b0;
      end else if (hs) begin
        mIdx++;
      end
      if (valid_in && !rdy) mOverflow = 1'b1;
    end
  end

  logic [N*W-1:0] vecA;
  logic [N*W-1:0] vecB;
  int             amCount;
  int             amIdxSeen;
  int             amValSeen;
  bit             done;

  initial begin
    // Reset held low for three cycles, then idle outputs.
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("lit_reset_ready", ready_in, 1'b1);
    checkOutput("lit_reset_valid", out_valid, 1'b0);
    checkOutput("lit_reset_ovf", overflow, 1'b0);
    checkOutput("lit_reset_data", out_data, 16'h0000);
    checkOutput("lit_reset_idx", out_idx, 0);

    // Basic stream: element i = i*4.
    for (int i = 0; i < N; i++) vecA[i*W +: W] = W'(i * 4);
    step();
    applyStimulus(1'b1, vecA, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("lit_basic_valid0", out_valid, 1'b1);
    checkOutput("lit_basic_idx0", out_idx, 0);
    checkOutput("lit_basic_data0", out_data, 16'h0000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("lit_basic_idx10", out_idx, 10);
    checkOutput("lit_basic_data10", out_data, 16'h0028);
    repeat (53) @(posedge clk);
    @(negedge clk);
    checkOutput("lit_basic_last", out_last, 1'b1);
    checkOutput("lit_basic_data63", out_data, 16'h00FC);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lit_basic_idle", out_valid, 1'b0);

    // Back-pressure: ready pattern 1,0,0,1 repeating.
    for (int i = 0; i < N; i++) vecA[i*W +: W] = W'($urandom);
    step();
    applyStimulus(1'b1, vecA, 1'b1);
    step();
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      applyStimulus(1'b0, '0, (c % 4 == 0) || (c % 4 == 3));
      step();
      if (!mActive) done = 1'b1;
    end
    checkOutput("bp_timeout", done, 1'b1);

    // Back-to-back: new vector on the final-handshake cycle.
    for (int i = 0; i < N; i++) vecA[i*W +: W] = W'(16'h0200 + i);
    for (int i = 0; i < N; i++) vecB[i*W +: W] = W'($urandom);
    vecB[0 +: W] = 16'hBEEF;
    applyStimulus(1'b1, vecA, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    repeat (63) @(posedge clk);
    #1;
    applyStimulus(1'b1, vecB, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("lit_b2b_valid", out_valid, 1'b1);
    checkOutput("lit_b2b_idx", out_idx, 0);
    checkOutput("lit_b2b_data", out_data, 16'hBEEF);
    checkOutput("lit_b2b_ovf", overflow, 1'b0);
    repeat (70) step();

    // Overflow: second vector offered at index 10 is dropped.
    for (int i = 0; i < N; i++) vecA[i*W +: W] = W'(16'h1000 + i);
    for (int i = 0; i < N; i++) vecB[i*W +: W] = 16'hFFFF;
    applyStimulus(1'b1, vecA, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(1'b1, vecB, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("lit_ovf_set", overflow, 1'b1);
    checkOutput("lit_ovf_idx", out_idx, 11);
    checkOutput("lit_ovf_data", out_data, 16'h100B);
    repeat (70) step();
    @(negedge clk);
    checkOutput("lit_ovf_sticky", overflow, 1'b1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("lit_ovf_cleared", overflow, 1'b0);

    // Argmax: ties at 5 and 40, lower index wins.
    for (int i = 0; i < N; i++) vecA[i*W +: W] = 16'h0010;
    vecA[5*W +: W]  = 16'h0100;
    vecA[40*W +: W] = 16'h0100;
    step();
    applyStimulus(1'b1, vecA, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    amCount = 0;
    amIdxSeen = 0;
    amValSeen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
`ifdef SOFTMAX_ARGMAX_EN
      if (argmax_valid) begin
        amCount++;
        amIdxSeen = int'(argmax_idx);
        amValSeen = int'(argmax_val);
      end
`endif
    end
`ifdef SOFTMAX_ARGMAX_EN
    checkOutput("lit_am_pulses", amCount, 1);
    checkOutput("lit_am_idx", amIdxSeen, 5);
    checkOutput("lit_am_val", amValSeen, 16'h0100);
`endif
    step();

    // Random traffic with one mid-stream reset.
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < N; i++)
        vecA[i*W +: W] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      applyStimulus($urandom_range(0, 24) == 0, vecA, $urandom_range(0, 3) != 0);
      if (c == 450) rst = 1'b0;
      if (c == 452) rst = 1'b1;
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (80) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_prob_serializer.md
# softmax_prob_serializer

Downstream stage of the `softmax` block. It captures one full probability vector (`prob_flat`, N×16-bit Q8.8) on the softmax `valid_out` strobe, then streams it out one element per handshake over a valid/ready interface, index 0 first. It provides back-pressure status to the upstream stage and an optional running argmax over each streamed vector.

## Interface
Parameters:
- `N`, 64, number of vector elements; must be ≥ 2.
- `W`, 16, element width (Q8.8, unsigned probability).

Ports:
- `clk`, input, 1, single clock; all logic on the rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `valid_in`, input, 1, one-cycle strobe; driven by softmax `valid_out`.
- `prob_flat`, input, N*W, vector; element i is `prob_flat[i*W +: W]`.
- `ready_in`, output, 1, the block accepts `valid_in` this cycle (combinational).
- `overflow`, output, 1, sticky flag; a vector was dropped.
- `out_valid`, output, 1, `out_data` is valid.
- `out_ready`, input, 1, consumer accepts the current element.
- `out_data`, output, W, current element.
- `out_idx`, output, $clog2(N), index of the current element.
- `out_last`, output, 1, the current element is index N-1.
- `argmax_valid`, output, 1, one-cycle pulse (only when `SOFTMAX_ARGMAX_EN` is defined).
- `argmax_idx`, output, $clog2(N), index of the maximum element (macro only).
- `argmax_val`, output, W, value of the maximum element (macro only).

## Operation
- Two states: IDLE and STREAM.
- A handshake is `out_valid && out_ready`.
- The final handshake is a handshake with `out_idx == N-1`.
- `ready_in` = (state == IDLE) || final handshake.
- Capture: when `valid_in && ready_in`, register the whole `prob_flat` into the N×W buffer, set `out_idx` to 0 and go to STREAM.
- STREAM:
  - `out_valid` = 1.
  - `out_data` = buffer[`out_idx`].
  - `out_last` = (`out_idx` == N-1).
  - On each handshake, `out_idx` increments.
  - On the final handshake, go to IDLE, unless a capture occurs in the same cycle. In that case, stay in STREAM with `out_idx` = 0 and the new vector in the buffer.
- If `out_ready` is low, `out_data` and `out_idx` hold their values and `out_valid` stays high. There is no timeout.
- Drop: when `valid_in && !ready_in`, the incoming vector is discarded, the buffer is unaffected and `overflow` is set. `overflow` is cleared only by reset.
- IDLE: `out_valid` = 0, `out_last` = 0. `out_data` shows buffer[`out_idx`], but consumers must ignore it.
- No arithmetic is performed on the data path. Elements pass through bit-exact.

## Timing
- Reset (asynchronous, `rst` low) sets state to IDLE and forces `out_valid`, `out_last`, `overflow`, `out_idx`, `out_data`, `argmax_valid`, `argmax_idx` and `argmax_val` to 0. The buffer is cleared to 0.
- Reset asserted mid-stream aborts the vector immediately. No partial `out_last` or argmax pulse is produced.
- Latency: a capture at edge k gives `out_valid` = 1 after edge k, with index 0 presented.
- With `out_ready` held high, the final handshake for N=64 occurs at edge k+64.
- Maximum throughput is one vector per N cycles, with no bubble when `valid_in` coincides with the final handshake.
- `ready_in` is combinational from state, `out_idx` and `out_ready`. `out_valid`, `out_data`, `out_idx` and `out_last` are registered or decoded from registers only. There is no combinational path from `out_ready` to `out_valid`.

## Configuration
- Macro `SOFTMAX_ARGMAX_EN`.
- Defined: a running maximum is tracked over handshaked elements.
  - The running maximum is initialised on capture.
  - The comparison is unsigned on W bits and uses strict greater-than, so ties keep the lower index.
  - `argmax_valid` pulses for 1 cycle on the edge after the final handshake.
  - `argmax_idx` and `argmax_val` update on that edge and are held until the next pulse.
- Undefined: the three argmax ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `softmax_pkg`:
  - `W` = 16 and `Q_FRAC` = 8 constants.
  - The serializer state enum (IDLE, STREAM).
  - A `clog2`-based index-width helper.
- Optional sub-module `softmax_argmax_tracker`:
  - Inputs: element, index, handshake, start, last.
  - Outputs: `argmax_valid`, `argmax_idx`, `argmax_val`.
  - Instantiated only under `SOFTMAX_ARGMAX_EN`.
- The buffer and the FSM stay in the top module.

## Test plan
- Reset then idle: hold `rst` low 3 cycles, then release -> all outputs 0, `ready_in` = 1, `out_valid` = 0.
- Basic stream: N=64, element i = i*4 (0x0000..0x00FC), `out_ready` = 1 -> 64 handshakes, `out_data` = i*4 at `out_idx` = i, `out_last` only at index 63, IDLE after.
- Back-pressure: toggle `out_ready` 1,0,0,1,... -> no element skipped or repeated, `out_data` stable while stalled.
- Back-to-back: second `valid_in` on the final-handshake cycle -> index 0 of the new vector presented next cycle with no gap, `overflow` = 0.
- Overflow: `valid_in` at `out_idx` = 10 during stream -> vector dropped, stream continues with the original data, `overflow` = 1 until reset.
- Argmax (macro defined): elements all 0x0010 except index 5 = 0x0100 and index 40 = 0x0100 -> `argmax_valid` pulses once after the final handshake, `argmax_idx` = 5, `argmax_val` = 0x0100.
